// File: rtl/inert_resp_pkg.sv
// -----------------------------------------------------------------------------
// inert_resp_pkg
// Shared definitions for the inertial-sensor SPI responder model:
//   - register addresses (7-bit, as carried in frame bits 14:8)
//   - WHO_AM_I identity value
//   - configuration values that together raise cfg_ok
//   - serial front-end state enum
// -----------------------------------------------------------------------------
package inert_resp_pkg;

  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_CTRL5     = 7'h14;
  localparam logic [6:0] ADDR_PTCH_L    = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H    = 7'h23;
  localparam logic [6:0] ADDR_AZ_L      = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H      = 7'h2D;

  localparam logic [7:0] WHO_AM_I_VAL   = 8'h6A;

  localparam logic [7:0] CFG_INT1_CTRL  = 8'h02;
  localparam logic [7:0] CFG_CTRL1_XL   = 8'h53;
  localparam logic [7:0] CFG_CTRL2_G    = 8'h50;
  localparam logic [7:0] CFG_CTRL5      = 8'h60;

  // IDLE: waiting for select; CMD: bits 1-8; DATA: bits 9-16;
  // DONE: all 16 bits seen, waiting for select release.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spi_serf_shift.sv
// -----------------------------------------------------------------------------
// spi_serf_shift
// SPI serial front end: synchronizes SS_n/SCLK/MOSI into clk, detects SCLK and
// SS_n edges, counts bits, shifts MOSI in on SCLK rise and MISO out on SCLK
// fall.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   SS_n, SCLK    raw SPI select / clock (asynchronous)
//   MOSI          raw SPI data in
//   MISO          SPI data out, forced 0 while synchronized select is high
//   rd_data       read byte for rd_addr, supplied by the register file
//   rd_addr       address of the command byte, valid the clock after bit 8
//   frame         the 16 received bits (valid when frm_done is high)
//   frm_done      one-clock pulse when a full frame ends with SS_n rise
//   state         current front-end state (debug visibility)
//
// Handshake: frm_done is a single-cycle valid with no ready; the consumer must
// take frame on that clock.  rd_data is sampled one clock after the 8th SCLK
// rise, so SCLK half-periods must span at least a few clk cycles.
// -----------------------------------------------------------------------------
module spi_serf_shift
  import inert_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [7:0]  rd_data,
  output logic [6:0]  rd_addr,
  output logic [15:0] frame,
  output logic        frm_done,
  output state_t      state
);

  logic [1:0]  ss_ff;
  logic [1:0]  sclk_ff;
  logic [1:0]  mosi_ff;
  logic        ss_prev;
  logic        sclk_prev;
  logic        ss;
  logic        sclk;
  logic        mosi;
  logic        ss_rise;
  logic        ss_fall;
  logic        sclk_rise;
  logic        sclk_fall;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_in;
  logic [7:0]  miso_sr;
  logic        miso_q;
  logic        load;

  assign ss        = ss_ff[1];
  assign sclk      = sclk_ff[1];
  assign mosi      = mosi_ff[1];
  assign ss_rise   = ss & ~ss_prev;
  assign ss_fall   = ~ss & ss_prev;
  assign sclk_rise = sclk & ~sclk_prev;
  assign sclk_fall = ~sclk & sclk_prev;

  assign rd_addr = shift_in[6:0];
  assign frame   = shift_in;
  assign MISO    = miso_q & ~ss;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Select synchronizer resets to "asserted" so that a frame already in
      // progress cannot look like a fresh SS_n fall; a real high then low is
      // needed before the next frame is decoded.
      ss_ff     <= 2'b00;
      ss_prev   <= 1'b0;
      sclk_ff   <= 2'b11;
      sclk_prev <= 1'b1;
      mosi_ff   <= 2'b00;
      state     <= ST_IDLE;
      bit_cnt   <= 5'd0;
      shift_in  <= 16'h0000;
      miso_sr   <= 8'h00;
      miso_q    <= 1'b0;
      load      <= 1'b0;
      frm_done  <= 1'b0;
    end else begin
      ss_ff     <= {ss_ff[0], SS_n};
      sclk_ff   <= {sclk_ff[0], SCLK};
      mosi_ff   <= {mosi_ff[0], MOSI};
      ss_prev   <= ss;
      sclk_prev <= sclk;
      frm_done  <= 1'b0;
      load      <= 1'b0;

      // Read byte is loaded one clock after the 8th rise, once the command
      // byte is registered; write frames shift out zeros.
      if (load) begin
        miso_sr <= shift_in[7] ? rd_data : 8'h00;
      end

      case (state)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall) begin
            state    <= ST_CMD;
            bit_cnt  <= 5'd0;
            shift_in <= 16'h0000;
            miso_sr  <= 8'h00;
          end
        end
        ST_CMD, ST_DATA: begin
          if (ss_rise) begin
            state  <= ST_IDLE;  // short frame: abort silently
            miso_q <= 1'b0;
          end else begin
            if (sclk_fall) begin
              miso_q  <= miso_sr[7];
              miso_sr <= {miso_sr[6:0], 1'b0};
            end
            if (sclk_rise) begin
              shift_in <= {shift_in[14:0], mosi};
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                state <= ST_DATA;
                load  <= 1'b1;
              end
              if (bit_cnt == 5'd15) begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          // Extra SCLK edges are ignored here.
          if (ss_rise) begin
            state    <= ST_IDLE;
            frm_done <= 1'b1;
            miso_q   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/inert_sensor_resp.sv
// -----------------------------------------------------------------------------
// inert_sensor_resp
// Behavioural SPI responder for an inertial sensor: configuration registers,
// WHO_AM_I, pitch-rate / Z-acceleration sample registers with a data-ready
// interrupt and a read lock that keeps the 16-bit pair coherent.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   SS_n, SCLK, MOSI    SPI inputs (asynchronous to clk)
//   MISO                SPI data out
//   INT                 data-ready interrupt
//   ptch_rt_in, AZ_in   new sample values
//   new_smpl            one-clock strobe qualifying ptch_rt_in/AZ_in
//   frm_done            one-clock pulse per completed 16-bit frame
//   cfg_ok              all four configuration registers hold required values
//   state               serial front-end state (debug visibility)
//
// Configuration macro INERT_RESP_AUTO_SMPL_EN: when defined, an internal
// counter produces a sample event every SMPL_PERIOD clocks and new_smpl is
// ignored; when undefined, sample events come only from new_smpl.
//
// Lock: reading pitch-rate L sets lock and clears INT; reading AZ H releases
// lock.  Samples arriving while locked are parked (latest wins) and applied on
// the releasing clock.
// -----------------------------------------------------------------------------
module inert_sensor_resp
  import inert_resp_pkg::*;
#(
  parameter int SMPL_PERIOD = 4096
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] ptch_rt_in,
  input  logic [15:0] AZ_in,
  input  logic        new_smpl,
  output logic        frm_done,
  output logic        cfg_ok,
  output state_t      state
);

  logic [7:0]  rd_data;
  logic [6:0]  rd_addr;
  logic [15:0] frame;
  logic [7:0]  int1_ctrl;
  logic [7:0]  ctrl1_xl;
  logic [7:0]  ctrl2_g;
  logic [7:0]  ctrl5;
  logic [15:0] ptch_q;
  logic [15:0] az_q;
  logic [15:0] pend_ptch;
  logic [15:0] pend_az;
  logic        pending;
  logic        lock;
  logic        int_q;
  logic        smpl_evt;

  spi_serf_shift u_serf (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rd_data  (rd_data),
    .rd_addr  (rd_addr),
    .frame    (frame),
    .frm_done (frm_done),
    .state    (state)
  );

`ifdef INERT_RESP_AUTO_SMPL_EN
  localparam int CW = (SMPL_PERIOD > 1) ? $clog2(SMPL_PERIOD) : 1;
  logic [CW-1:0] smpl_cnt;
  logic          tick;
  logic          unused_new_smpl;

  assign unused_new_smpl = new_smpl;

  always_ff @(posedge clk) begin
    if (rst) begin
      smpl_cnt <= '0;
      tick     <= 1'b0;
    end else if (smpl_cnt == CW'(SMPL_PERIOD - 1)) begin
      smpl_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      smpl_cnt <= smpl_cnt + 1'b1;
      tick     <= 1'b0;
    end
  end

  assign smpl_evt = tick;
`else
  localparam int unused_smpl_period = SMPL_PERIOD;
  assign smpl_evt = new_smpl;
`endif

  // Read mux, addressed by the command byte captured after bit 8.
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_INT1_CTRL: rd_data = int1_ctrl;
      ADDR_WHO_AM_I:  rd_data = WHO_AM_I_VAL;
      ADDR_CTRL1_XL:  rd_data = ctrl1_xl;
      ADDR_CTRL2_G:   rd_data = ctrl2_g;
      ADDR_CTRL5:     rd_data = ctrl5;
      ADDR_PTCH_L:    rd_data = ptch_q[7:0];
      ADDR_PTCH_H:    rd_data = ptch_q[15:8];
      ADDR_AZ_L:      rd_data = az_q[7:0];
      ADDR_AZ_H:      rd_data = az_q[15:8];
      default:        rd_data = 8'h00;
    endcase
  end

  logic [6:0] frm_addr;
  logic       frm_rd;
  logic       wr_en;
  logic       set_lock;
  logic       clr_lock;
  logic       lock_n;
  logic       apply_new;
  logic       apply_pend;
  logic       int_set;

  assign frm_addr = frame[14:8];
  assign frm_rd   = frm_done & frame[15];
  assign wr_en    = frm_done & ~frame[15];
  assign set_lock = frm_rd & (frm_addr == ADDR_PTCH_L);
  assign clr_lock = frm_rd & (frm_addr == ADDR_AZ_H);
  assign lock_n   = set_lock | (lock & ~clr_lock);
  // A sample on the releasing clock is newer than anything parked, so it wins.
  assign apply_new  = smpl_evt & ~lock_n;
  assign apply_pend = pending & lock & clr_lock & ~smpl_evt;
  // Setting INT takes priority over the clear from a pitch-L read.
  assign int_set    = int1_ctrl[1] & (smpl_evt | apply_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      int1_ctrl <= 8'h00;
      ctrl1_xl  <= 8'h00;
      ctrl2_g   <= 8'h00;
      ctrl5     <= 8'h00;
      ptch_q    <= 16'h0000;
      az_q      <= 16'h0000;
      pend_ptch <= 16'h0000;
      pend_az   <= 16'h0000;
      pending   <= 1'b0;
      lock      <= 1'b0;
      int_q     <= 1'b0;
      cfg_ok    <= 1'b0;
    end else begin
      cfg_ok <= (int1_ctrl == CFG_INT1_CTRL) && (ctrl1_xl == CFG_CTRL1_XL) &&
                (ctrl2_g == CFG_CTRL2_G) && (ctrl5 == CFG_CTRL5);

      if (wr_en) begin
        case (frm_addr)
          ADDR_INT1_CTRL: int1_ctrl <= frame[7:0];
          ADDR_CTRL1_XL:  ctrl1_xl  <= frame[7:0];
          ADDR_CTRL2_G:   ctrl2_g   <= frame[7:0];
          ADDR_CTRL5:     ctrl5     <= frame[7:0];
          default: ;
        endcase
      end

      lock <= lock_n;

      if (smpl_evt && lock_n) begin
        pend_ptch <= ptch_rt_in;
        pend_az   <= AZ_in;
        pending   <= 1'b1;
      end
      if (apply_new) begin
        ptch_q  <= ptch_rt_in;
        az_q    <= AZ_in;
        pending <= 1'b0;
      end
      if (apply_pend) begin
        ptch_q  <= pend_ptch;
        az_q    <= pend_az;
        pending <= 1'b0;
      end

      int_q <= int_set | (int_q & ~set_lock);
    end
  end

  assign INT = int_q;

endmodule

// File: tb/tb_inert_sensor_resp.sv
// -----------------------------------------------------------------------------
// tb_inert_sensor_resp
// Self-checking bench for inert_sensor_resp: drives SPI frames bit by bit with
// a slow SCLK, pushes expected read words to a queue as each frame is driven
// and pops/compares them when the frame completes.
// -----------------------------------------------------------------------------
module tb_inert_sensor_resp;
  import inert_resp_pkg::*;

  localparam int HP = 6;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        new_smpl;
  logic [15:0] ptch_rt_in;
  logic [15:0] AZ_in;
  logic        MISO;
  logic        INT;
  logic        frm_done;
  logic        cfg_ok;
  state_t      state;

  int n_cmp = 0;
  int n_err = 0;
  int frm_cnt = 0;
  int frm_exp = 0;
  logic [15:0] exp_q[$];

  inert_sensor_resp #(.SMPL_PERIOD(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .SS_n       (SS_n),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .INT        (INT),
    .ptch_rt_in (ptch_rt_in),
    .AZ_in      (AZ_in),
    .new_smpl   (new_smpl),
    .frm_done   (frm_done),
    .cfg_ok     (cfg_ok),
    .state      (state)
  );

  // ---------------- clock / frame monitor ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frm_done) frm_cnt++;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
    rx = 16'h0000;
    SS_n = 1'b0;
    clks(HP);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      if (i < 16) MOSI = tx[15-i];
      else        MOSI = 1'b1;
      clks(HP);
      if (i < 16) rx = {rx[14:0], MISO};
      SCLK = 1'b1;
      clks(HP);
    end
    SS_n = 1'b1;
    clks(HP + 4);
  endtask

  task automatic write_reg(input logic [15:0] f, input string tag);
    logic [15:0] rx;
    frm_exp++;
    spi_xfer(f, 16, rx);
    check({tag, "_miso"}, 32'(rx), 32'h0);
    check({tag, "_frm"}, frm_cnt, frm_exp);
  endtask

  task automatic read_reg(input logic [6:0] a, input logic [7:0] e, input string tag,
                          input int nbits = 16);
    logic [15:0] rx;
    logic [15:0] exp;
    exp_q.push_back({8'h00, e});
    frm_exp++;
    spi_xfer({1'b1, a, 8'h00}, nbits, rx);
    if (exp_q.size() == 0) begin
      check({tag, "_q"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 32'(rx), 32'(exp));
    end
    check({tag, "_frm"}, frm_cnt, frm_exp);
  endtask

  task automatic pulse_smpl(input logic [15:0] p, input logic [15:0] a);
    ptch_rt_in = p;
    AZ_in      = a;
    new_smpl   = 1'b1;
    clks(1);
    new_smpl   = 1'b0;
    clks(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rx;
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    new_smpl = 1'b0; ptch_rt_in = 16'h0; AZ_in = 16'h0;
    clks(3);
    rst = 1'b0;
    clks(3);
    check("rst_miso", 32'(MISO), 32'h0);
    check("rst_int", 32'(INT), 32'h0);
    check("rst_frm_done", 32'(frm_done), 32'h0);
    check("rst_cfg_ok", 32'(cfg_ok), 32'h0);
    check("rst_state", 32'(state), 32'(ST_IDLE));

    // Short frame (10 SCLKs) must not commit
    spi_xfer(16'h0D02, 10, rx);
    check("abort_frm", frm_cnt, frm_exp);
    read_reg(7'h0D, 8'h00, "abort_int1");

    // Lone CTRL5 write leaves cfg_ok low
    write_reg(16'h1460, "wr_ctrl5");
    clks(2);
    check("cfg_partial", 32'(cfg_ok), 32'h0);
    read_reg(7'h14, 8'h60, "rd_ctrl5");

    // Full configuration
    write_reg(16'h0D02, "wr_int1");
    write_reg(16'h1053, "wr_xl");
    write_reg(16'h1150, "wr_g");
    write_reg(16'h1460, "wr_c5");
    clks(2);
    check("cfg_full", 32'(cfg_ok), 32'h1);

    // WHO_AM_I, RO write ignored, unmapped read
    read_reg(7'h0F, 8'h6A, "whoami");
    write_reg(16'h0F55, "wr_ro");
    read_reg(7'h0F, 8'h6A, "whoami_ro");
    read_reg(7'h01, 8'h00, "unmapped");

    // Sample + interrupt + coherent read sequence
    check("int_idle", 32'(INT), 32'h0);
    pulse_smpl(16'h1234, 16'hFEDC);
    check("int_set", 32'(INT), 32'h1);
    read_reg(7'h22, 8'h34, "ptch_l");
    check("int_clr", 32'(INT), 32'h0);
    read_reg(7'h23, 8'h12, "ptch_h");
    read_reg(7'h2C, 8'hDC, "az_l");
    read_reg(7'h2D, 8'hFE, "az_h");

    // Sample arriving while locked is parked until AZ H read
    read_reg(7'h22, 8'h34, "lk_ptch_l");
    pulse_smpl(16'h5555, 16'hAAAA);
    read_reg(7'h23, 8'h12, "lk_ptch_h");
    read_reg(7'h2D, 8'hFE, "lk_az_h");
    check("lk_int", 32'(INT), 32'h1);
    read_reg(7'h22, 8'h55, "new_ptch_l");
    read_reg(7'h23, 8'h55, "new_ptch_h");
    read_reg(7'h2C, 8'hAA, "new_az_l");
    read_reg(7'h2D, 8'hAA, "new_az_h");

    // Extra SCLKs beyond 16 are ignored
    frm_exp++;
    spi_xfer(16'h0D00, 18, rx);
    check("long_wr_frm", frm_cnt, frm_exp);
    clks(2);
    check("long_wr_cfg", 32'(cfg_ok), 32'h0);
    read_reg(7'h0D, 8'h00, "long_wr_rd");
    read_reg(7'h0F, 8'h6A, "long_rd", 18);
    write_reg(16'h0D02, "rewr_int1");
    clks(2);
    check("recfg", 32'(cfg_ok), 32'h1);

    // Reset in the middle of a read
    pulse_smpl(16'h0BCD, 16'h0123);
    check("pre_rst_int", 32'(INT), 32'h1);
    SS_n = 1'b0;
    clks(HP);
    for (int i = 0; i < 10; i++) begin
      SCLK = 1'b0;
      if (i == 0) MOSI = 1'b1;
      else        MOSI = (i >= 4 && i <= 7) ? 1'b1 : 1'b0;  // 0x8F00
      clks(HP);
      SCLK = 1'b1;
      clks(HP);
    end
    rst = 1'b1;
    clks(2);
    check("mid_rst_miso", 32'(MISO), 32'h0);
    check("mid_rst_int", 32'(INT), 32'h0);
    check("mid_rst_cfg", 32'(cfg_ok), 32'h0);
    check("mid_rst_frm_done", 32'(frm_done), 32'h0);
    rst = 1'b0;
    clks(2);
    check("mid_rst_state", 32'(state), 32'(ST_IDLE));
    for (int i = 10; i < 16; i++) begin
      SCLK = 1'b0;
      MOSI = 1'b0;
      clks(HP);
      SCLK = 1'b1;
      clks(HP);
    end
    SS_n = 1'b1;
    clks(HP + 4);
    check("mid_rst_nofrm", frm_cnt, frm_exp);
    read_reg(7'h0F, 8'h6A, "post_rst_whoami");
    read_reg(7'h0D, 8'h00, "post_rst_int1");
    read_reg(7'h22, 8'h00, "post_rst_ptch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
